// File: rtl/run_ctrl.sv
// run_ctrl -- program-run sequencer for the single-cycle core.
//
// Turns the host start pulse (falling edge of req) into one program run:
// clears and advances the program counter, opens the register-file write
// permit while running, and stops on a halt instruction or when the
// cycle budget runs out. done is a level that holds until the next start.
//
// Ports
//   clk            system clock, all state on the rising edge
//   reset          synchronous active-high reset (does not clear req_q)
//   req            start request; the run starts on its falling edge
//   halt           instruction at pc is a halt
//   stall          current instruction needs another cycle; hold pc
//   branch_taken   current instruction redirects pc
//   branch_target  redirect address
//   pc             instruction-memory address
//   rf_we_en       register-file / data-memory write permit
//   done           run finished (level)
//   timeout        run ended on the cycle budget rather than on halt
//   cycles         RUN-state cycles counted in the current or last run
//
// MAX_CYCLES must be >= 2 and < 2**CYC_W.
module run_ctrl #(
  parameter int PC_W       = 10,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             rf_we_en,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  state_e           state_q;
  logic             req_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             we_q, done_q, to_q;
  logic             start;
  logic             last_cyc;

  // req_q is deliberately outside reset so reset may be tied to req:
  // the cycle after a combined pulse still sees req_q=1 and req=0.
  always_ff @(posedge clk) begin
    req_q <= req;
  end

  assign start    = req_q & ~req & ~reset;
  assign last_cyc = (cyc_q == LAST_CYC);

  // Next pc for a RUN cycle that neither times out nor halts.
  // Natural PC_W-bit overflow gives the silent wrap to 0.
  always_comb begin
    pc_d = pc_q + PC_ONE;
    if (stall)             pc_d = pc_q;
    else if (branch_taken) pc_d = branch_target;
  end

  assign cyc_d = cyc_q + CYC_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cyc_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        S_INIT: begin
          // Clears were applied on entry so INIT already shows zeros;
          // repeated here so INIT is self-contained.
          state_q <= S_RUN;
          pc_q    <= '0;
          cyc_q   <= '0;
          to_q    <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b1;
        end

        S_RUN: begin
          cyc_q <= cyc_d;
          if (last_cyc) begin
            // Budget exhausted: wins over halt and stall, pc holds.
            state_q <= S_FIN;
            to_q    <= 1'b1;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end else if (halt && !stall) begin
            // A stalled halt is not yet the retiring instruction.
            state_q <= S_FIN;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q <= pc_d;
          end
        end

        S_FIN: begin
          if (start) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          pc_q    <= '0;
          cyc_q   <= '0;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          to_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign rf_we_en = we_q;
  assign done     = done_q;
  assign timeout  = to_q;
  assign cycles   = cyc_q;

endmodule
